// File: rtl/vec_alu_pkg.sv
// Shared opcode, state and register-address definitions for the vector ALU.
package vec_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_A1 = 2'd0;
  localparam logic [1:0] ADDR_A2 = 2'd1;
  localparam logic [1:0] ADDR_A3 = 2'd2;
  localparam logic [1:0] ADDR_A4 = 2'd3;

  // Opcodes 000..011 are the multi-cycle arithmetic operations.
  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/vec_lane_unit.sv
// One combinational lane: produces the double-width {hi,lo} result of a op b.
module vec_lane_unit
  import vec_alu_pkg::*;
#(
  parameter int LANE_W = 32
) (
  input  logic [2:0]        op,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] lo,
  output logic [LANE_W-1:0] hi,
  output logic              dz
);

  logic [2*LANE_W-1:0] a_ext;
  logic [2*LANE_W-1:0] b_ext;
  logic [2*LANE_W-1:0] sum_w;
  logic [2*LANE_W-1:0] diff_w;
  logic [2*LANE_W-1:0] prod_w;

  assign a_ext  = {{LANE_W{1'b0}}, a};
  assign b_ext  = {{LANE_W{1'b0}}, b};
  assign sum_w  = a_ext + b_ext;
  // Double-width subtraction yields an all-ones upper half exactly when a < b.
  assign diff_w = a_ext - b_ext;
  assign prod_w = a_ext * b_ext;

  // Select the operation result; a zero divisor saturates the quotient.
  always_comb begin
    lo = '0;
    hi = '0;
    dz = 1'b0;
    case (op)
      OP_ADD: begin
        lo = sum_w[LANE_W-1:0];
        hi = sum_w[2*LANE_W-1:LANE_W];
      end
      OP_SUB: begin
        lo = diff_w[LANE_W-1:0];
        hi = diff_w[2*LANE_W-1:LANE_W];
      end
      OP_MUL: begin
        lo = prod_w[LANE_W-1:0];
        hi = prod_w[2*LANE_W-1:LANE_W];
      end
      OP_DIV: begin
        if (b == '0) begin
          lo = '1;
          hi = a;
          dz = 1'b1;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: begin
        lo = '0;
        hi = '0;
        dz = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/vector_alu_seq.sv
// Four-register vector ALU: loads A1..A4 and computes A1 op A2 into A4:A3,
// LANES_PER_CYCLE lanes per cycle under a start/busy/done handshake.
module vector_alu_seq
  import vec_alu_pkg::*;
#(
  parameter int LANE_W          = 32,
  parameter int LANES           = 16,
  parameter int LANES_PER_CYCLE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2:0]                opcode,
  input  logic [1:0]                reg_addr,
  input  logic [LANES*LANE_W-1:0]   load_data,
  output logic                      busy,
  output logic                      done,
  output logic                      div_zero,
  output logic [LANES*LANE_W-1:0]   a1_out,
  output logic [LANES*LANE_W-1:0]   a2_out,
  output logic [LANES*LANE_W-1:0]   a3_out,
  output logic [LANES*LANE_W-1:0]   a4_out
);

  localparam int NG    = LANES / LANES_PER_CYCLE;
  localparam int VW    = LANES * LANE_W;
  localparam int GRP_W = LANES_PER_CYCLE * LANE_W;
  localparam int GW    = (NG > 1) ? $clog2(NG) : 1;
  localparam int IW    = (VW > 1) ? $clog2(VW) : 1;

  state_t          state_q, state_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [2:0]      op_q, op_d;
  logic            dz_q, dz_d;
  logic [VW-1:0]   a1_q, a1_d;
  logic [VW-1:0]   a2_q, a2_d;
  logic [VW-1:0]   a3_q, a3_d;
  logic [VW-1:0]   a4_q, a4_d;

  // Bit offset of the group currently being processed.
  logic [IW-1:0]   grp_base;
  assign grp_base = IW'(grp_q) * IW'(GRP_W);

  logic [GRP_W-1:0]           grp_lo;
  logic [GRP_W-1:0]           grp_hi;
  logic [LANES_PER_CYCLE-1:0] grp_dz;

  // One lane unit per lane of the active group, fed from A1/A2 slices.
  for (genvar gi = 0; gi < LANES_PER_CYCLE; gi++) begin : g_lane
    logic [IW-1:0] lane_base;
    assign lane_base = grp_base + IW'(gi * LANE_W);

    vec_lane_unit #(
      .LANE_W(LANE_W)
    ) u_lane (
      .op (op_q),
      .a  (a1_q[lane_base +: LANE_W]),
      .b  (a2_q[lane_base +: LANE_W]),
      .lo (grp_lo[gi*LANE_W +: LANE_W]),
      .hi (grp_hi[gi*LANE_W +: LANE_W]),
      .dz (grp_dz[gi])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: arithmetic walks all groups, LOAD/NOP finish immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = is_arith(opcode) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (grp_q == GW'(NG - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy outside IDLE, done for the single DONE cycle.
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Datapath next state: register loads, operation latch and group write-back.
  always_comb begin
    a1_d = a1_q;
    a2_d = a2_q;
    a3_d = a3_q;
    a4_d = a4_q;
    op_d = op_q;
    dz_d = dz_q;
    grp_d = grp_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_arith(opcode)) begin
            op_d  = opcode;
            dz_d  = 1'b0;
            grp_d = '0;
          end else if (opcode == OP_LOAD) begin
            case (reg_addr)
              ADDR_A1: a1_d = load_data;
              ADDR_A2: a2_d = load_data;
              ADDR_A3: a3_d = load_data;
              ADDR_A4: a4_d = load_data;
              default: a1_d = a1_q;
            endcase
          end
        end
      end
      ST_RUN: begin
        a3_d[grp_base +: GRP_W] = grp_lo;
        a4_d[grp_base +: GRP_W] = grp_hi;
        dz_d  = dz_q | (|grp_dz);
        grp_d = (grp_q == GW'(NG - 1)) ? '0 : grp_q + GW'(1);
      end
      default: begin
        grp_d = grp_q;
      end
    endcase
  end

  // Datapath registers; reset clears everything including partial results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q  <= '0;
      a2_q  <= '0;
      a3_q  <= '0;
      a4_q  <= '0;
      op_q  <= OP_ADD;
      dz_q  <= 1'b0;
      grp_q <= '0;
    end else begin
      a1_q  <= a1_d;
      a2_q  <= a2_d;
      a3_q  <= a3_d;
      a4_q  <= a4_d;
      op_q  <= op_d;
      dz_q  <= dz_d;
      grp_q <= grp_d;
    end
  end

  assign div_zero = dz_q;
  assign a1_out   = a1_q;
  assign a2_out   = a2_q;
  assign a3_out   = a3_q;
  assign a4_out   = a4_q;

endmodule

// File: doc/vector_alu_seq.md
Name: vector_alu_seq

Overview:
- Parametrised successor to the fixed 4×512-bit vector CPU datapath.
- Holds four vector registers A1..A4, each LANES lanes of LANE_W bits.
- Loads A1/A2 from an external bus. Executes lane-wise ADD/SUB/MUL/DIV into A4:A3, processing LANES_PER_CYCLE lanes per cycle under a start/busy/done handshake.
- Sits between the instruction sequencer and the vector memory.

Parameters:
LANE_W, 32, bits per lane
LANES, 16, lanes per vector register
LANES_PER_CYCLE, 4, lanes processed per RUN cycle; must divide LANES (NG = LANES/LANES_PER_CYCLE groups)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
opcode  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 LOAD, 101-111 NOP
reg_addr  in  2  LOAD target: 00 A1, 01 A2, 10 A3, 11 A4
load_data  in  LANES*LANE_W  LOAD value
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
div_zero  out  1  last DIV hit a zero divisor in at least one lane
a1_out..a4_out  out  LANES*LANE_W each  live register contents

Behaviour:
- Lane i occupies bits [LANE_W*i +: LANE_W]. Group g covers lanes g*LPC .. g*LPC+LPC-1.
- Reset (async, any state): A1..A4=0, div_zero=0, state=IDLE, group counter=0, busy=0, done=0.
- FSM states: IDLE, RUN, DONE.
- IDLE + start:
  - LOAD: reg[reg_addr] := load_data at the accepting edge; → DONE.
  - NOP: no register change; → DONE.
  - ADD/SUB/MUL/DIV: latch opcode; clear div_zero; g := 0; → RUN.
- IDLE without start: stay in IDLE.
- RUN: each edge writes group g of A3/A4 from A1/A2, then g++.
  - At the edge where g = NG-1: → DONE.
  - Opcode is latched, so input opcode changes during RUN are ignored.
- DONE: done=1 for exactly one cycle; → IDLE. A new start is accepted only from the following cycle.
- Latency, counting the start-accept cycle as cycle 0:
  - LOAD/NOP: done in cycle 1.
  - Arithmetic: done in cycle NG+1.
- start while busy is ignored; no queuing.
- Per-lane arithmetic (unsigned; A1 = a, A2 = b):
  - ADD: {A4,A3} = zero-extended a + b, so A4 lane ∈ {0,1}.
  - SUB: A3 = (a - b) mod 2^W; A4 lane = all-ones if a < b, else 0 (2W-bit two's-complement result).
  - MUL: {A4,A3} = full 2W-bit product.
  - DIV, b ≠ 0: A3 = a / b, A4 = a % b.
  - DIV, b = 0: A3 = all-ones, A4 = a, div_zero set (sticky until the next arithmetic start).
- A1/A2 are never written by arithmetic, so operands stay stable throughout RUN.
- Reset mid-RUN: abort immediately; done is never asserted for the aborted op; partially written A3/A4 are cleared by reset.

Decomposition:
- Package vec_alu_pkg:
  - opcode localparams (OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_LOAD);
  - state encoding (ST_IDLE, ST_RUN, ST_DONE);
  - register-address constants.
- Sub-module vec_lane_unit (combinational, parameter LANE_W):
  - inputs: op, a, b;
  - outputs: lo, hi, dz;
  - instantiated LANES_PER_CYCLE times and fed from group-indexed slices.

Test Plan (defaults, NG=4):
1. rst=1 for 2 cycles, release → all a*_out=0, busy=0, done=0, div_zero=0; start while rst=1 has no effect.
2. LOAD A1 with lane0=1, lane6=1048576, then LOAD A2 with lane0=2, lane6=1048576 → each load gives done in cycle 1; a1_out/a2_out match bit-exact.
3. MUL → busy high in cycles 1-4, done in cycle 5; lane6 A3=0, A4=0x100; lane0 A3=2, A4=0.
4. DIV with A1 lane0=7, lane1=5; A2 lane0=2, lane1=0 → lane0 A3=3, A4=1; lane1 A3=0xFFFFFFFF, A4=5; div_zero=1. A following ADD clears div_zero.
5. Carry and borrow:
   - ADD, A1 lane0=0xFFFFFFFF, A2 lane0=1 → A3=0, A4=1.
   - SUB, A1 lane0=1, A2 lane0=2 → A3=0xFFFFFFFF, A4=0xFFFFFFFF.
6. Robustness during MUL:
   - start+LOAD pulsed in cycle 2 is ignored (A1 unchanged, done only in cycle 5).
   - In a second MUL, async rst in cycle 2 → all registers 0 immediately, busy=0, no done pulse.
